// File: rtl/count_sequencer.sv
// Sequences an external up/down counter: load a start value, step it every
// prescale+1 cycles until it reaches the end value, then pulse done.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_up,
  input  logic [PW-1:0]    cmd_prescale,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] start_reg;
  logic [WIDTH-1:0] end_reg;
  logic             up_reg;
  logic [PW-1:0]    prescale_reg;
  logic [PW-1:0]    pc;

  logic at_end;
  logic tick;

  assign at_end = (cnt_value == end_reg);
  assign tick   = (pc == prescale_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_reg    <= '0;
      end_reg      <= '0;
      up_reg       <= 1'b0;
      prescale_reg <= '0;
      pc           <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort has no meaning here; a command alongside it is still taken
          if (cmd_valid) begin
            start_reg    <= cmd_start;
            end_reg      <= cmd_end;
            up_reg       <= cmd_up;
            prescale_reg <= cmd_prescale;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            pc    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (at_end) begin
            state <= DONE;
          end else if (pause) begin
            pc <= pc;
          end else if (tick) begin
            pc <= '0;
          end else begin
            pc <= pc + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Abort suppresses every counter/completion strobe in the cycle it is seen.
  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cnt_load     = (state == LOAD) && !abort;
  assign done         = (state == DONE) && !abort;
  assign cnt_en       = (state == RUN) && !abort && !at_end && !pause && tick;
  assign cnt_up       = up_reg;
  assign cnt_load_val = start_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural counter and a
// schedule-based reference model checked every cycle.
module tb_count_sequencer;
  localparam int W  = 4;
  localparam int PW = 4;
  localparam int ML = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_up = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cmd_start = '0;
  logic [W-1:0]  cmd_end = '0;
  logic [PW-1:0] cmd_prescale = '0;
  logic [W-1:0]  cnt_value;
  logic [W-1:0]  cnt_load_val;
  logic          cmd_ready, cnt_load, cnt_en, cnt_up, busy, done;
  logic [W-1:0]  cnt_q = '0;

  count_sequencer #(.WIDTH(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up),
    .cmd_prescale(cmd_prescale), .pause(pause), .abort(abort),
    .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External counter datapath: registered load / enable / direction.
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_load_val;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign cnt_value = cnt_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  // Expected per-cycle behaviour, indexed by cycle relative to the accept cycle.
  bit         e_busy [ML+2];
  bit         e_load [ML+2];
  bit         e_en   [ML+2];
  bit         e_done [ML+2];
  bit         e_up   [ML+2];
  bit         acc    [ML+2];
  bit         rcyc   [ML+2];
  bit         noen   [ML+2];
  bit         valchk [ML+2];
  bit         lvchk  [ML+2];
  logic [3:0] e_val  [ML+2];
  logic [3:0] e_lv   [ML+2];
  logic [3:0] dut_val[ML+2];
  bit         m_up = 1'b0;

  bit active = 1'b0;
  int base = 0;
  int tlen = 0;
  int first_done = -1;
  int last_done = -1;
  int rr;

  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s rel_cycle=%0d got=%0d expected=%0d", nm, r, $signed(act), $signed(exp));
    end
  endtask

  task automatic build(input int len, input logic [3:0] s, input logic [3:0] e, input bit u,
                       input int p, input int plo, input int phi, input int ab, input int rs,
                       input int vhi);
    int a, c, act, steps, n, m, cut;
    bit is_rst;
    logic [3:0] d;
    for (int r = 0; r <= ML + 1; r++) begin
      e_busy[r] = 0; e_load[r] = 0; e_en[r] = 0; e_done[r] = 0; acc[r] = 0;
      rcyc[r] = 0; noen[r] = 0; lvchk[r] = 0; e_lv[r] = s; valchk[r] = (r >= 2);
    end
    a = 0;
    while (a <= vhi && a < len) begin
      acc[a] = 1;
      d = u ? e - s : s - e;
      n = int'(d);
      // The k-th step lands on the cycle where the count of unpaused run
      // cycles reaches k*(p+1).
      steps = 0; act = 0; c = a + 2;
      while (steps < n && c < ML) begin
        if (!(c >= plo && c <= phi)) begin
          act++;
          if (act == (steps + 1) * (p + 1)) begin
            e_en[c] = 1;
            steps++;
          end
        end
        c++;
      end
      m = c;
      for (int r = a + 1; r <= m + 1; r++) e_busy[r] = 1;
      e_load[a + 1] = 1;
      lvchk[a + 1] = 1;
      e_done[m + 1] = 1;
      cut = -1; is_rst = 0;
      if (ab > a && ab <= m + 1) cut = ab;
      else if (rs > a && rs <= m + 1) begin cut = rs; is_rst = 1; end
      if (cut >= 0) begin
        for (int r = cut + 1; r <= m + 1; r++) begin
          e_busy[r] = 0; e_en[r] = 0; e_done[r] = 0; e_load[r] = 0; lvchk[r] = 0;
        end
        if (is_rst) begin
          rcyc[cut] = 1;
          noen[cut] = 1;
          for (int r = cut + 1; r <= ML + 1; r++) begin
            valchk[r] = 0; lvchk[r] = 1; e_lv[r] = 4'd0;
          end
        end else begin
          e_en[cut] = 0; e_load[cut] = 0; e_done[cut] = 0;
        end
        a = cut + 1;
      end else begin
        a = m + 2;
      end
    end
    e_up[0] = m_up;
    e_val[0] = cnt_q;
    for (int r = 0; r < len; r++) begin
      e_up[r + 1]  = acc[r] ? u : (rcyc[r] ? 1'b0 : e_up[r]);
      e_val[r + 1] = e_load[r] ? s : (e_en[r] ? (e_up[r] ? e_val[r] + 4'd1 : e_val[r] - 4'd1) : e_val[r]);
    end
    m_up = e_up[len];
  endtask

  task automatic run(input int len, input logic [3:0] s, input logic [3:0] e, input bit u,
                     input int p, input int plo, input int phi, input int ab, input int rs,
                     input int vhi);
    build(len, s, e, u, p, plo, phi, ab, rs, vhi);
    tlen = len; first_done = -1; last_done = -1;
    base = cyc + 1;
    active = 1;
    for (int r = 0; r < len; r++) begin
      @(posedge clk); #1;
      cmd_valid = (r <= vhi);
      cmd_start = s; cmd_end = e; cmd_up = u; cmd_prescale = p[PW-1:0];
      pause = (r >= plo && r <= phi);
      abort = (r == ab);
      rst   = (r == rs);
    end
    @(posedge clk); #1;
    active = 0;
    cmd_valid = 0; pause = 0; abort = 0; rst = 0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (active) begin
      rr = cyc - base;
      if (rr >= 0 && rr < tlen) begin
        chk("cmd_ready", rr, cmd_ready, !e_busy[rr]);
        chk("busy", rr, busy, e_busy[rr]);
        chk("cnt_load", rr, cnt_load, e_load[rr]);
        chk("done", rr, done, e_done[rr]);
        chk("cnt_up", rr, cnt_up, e_up[rr]);
        if (!noen[rr])  chk("cnt_en", rr, cnt_en, e_en[rr]);
        if (valchk[rr]) chk("cnt_value", rr, cnt_value, e_val[rr]);
        if (lvchk[rr])  chk("cnt_load_val", rr, cnt_load_val, e_lv[rr]);
        dut_val[rr] = cnt_value;
        if (done === 1'b1) begin
          if (first_done < 0) first_done = rr;
          last_done = rr;
        end
      end
    end
  end

  initial begin
    cmd_valid = 1; cmd_start = 4'd9; cmd_end = 4'd3; cmd_up = 1; cmd_prescale = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("rst_cmd_ready", -1, cmd_ready, 1);
    chk("rst_busy", -1, busy, 0);
    chk("rst_done", -1, done, 0);
    chk("rst_cnt_en", -1, cnt_en, 0);
    chk("rst_cnt_load", -1, cnt_load, 0);
    chk("rst_cnt_load_val", -1, cnt_load_val, 0);
    chk("rst_cnt_up", -1, cnt_up, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // basic up: 2 -> 5, P=0
    run(9, 4'd2, 4'd5, 1'b1, 0, 1, 0, -1, -1, 0);
    chk("basic_done_cycle", 0, first_done, 6);
    chk("basic_value_c5", 5, dut_val[5], 5);

    // wrap up: 14 -> 1
    run(9, 4'd14, 4'd1, 1'b1, 0, 1, 0, -1, -1, 0);
    chk("wrap_done_cycle", 0, first_done, 6);
    chk("wrap_value_c4", 4, dut_val[4], 0);

    // down with prescale: 3 -> 12, P=1
    run(20, 4'd3, 4'd12, 1'b0, 1, 1, 0, -1, -1, 0);
    chk("down_done_cycle", 0, first_done, 17);
    chk("down_value_c16", 16, dut_val[16], 12);

    // pause cycles 3..5
    run(12, 4'd2, 4'd5, 1'b1, 0, 3, 5, -1, -1, 0);
    chk("pause_done_cycle", 0, first_done, 9);
    chk("pause_value_c6", 6, dut_val[6], 3);

    // abort in cycle 3
    run(8, 4'd2, 4'd5, 1'b1, 0, 1, 0, 3, -1, 0);
    chk("abort_done_cycle", 0, first_done, -1);
    chk("abort_value_c5", 5, dut_val[5], 3);

    // reset in cycle 3
    run(8, 4'd2, 4'd5, 1'b1, 0, 1, 0, -1, 3, 0);
    chk("rst_done_cycle", 0, first_done, -1);

    // N=0 with cmd_valid held: back-to-back
    run(10, 4'd7, 4'd7, 1'b1, 0, 1, 0, -1, -1, 4);
    chk("b2b_first_done", 0, first_done, 3);
    chk("b2b_last_done", 0, last_done, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
